// File: rtl/pep_ldg_unpack_pkg.sv
// Shared sizing, command type and FSM encoding for the GLWE-load AXI unpacker.
// Derived counts follow from N, the AXI word width and the output beat width.
package pep_ldg_unpack_pkg;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N           = 64;
  localparam int MOD_Q_W     = 31;
  localparam int COEF_NB     = 4;
  localparam int AXI_DATA_W  = 512;
  localparam int SLOT_W      = 32;

  localparam int AXI_COEF_NB = AXI_DATA_W / SLOT_W;
  localparam int WORD_NB     = N / AXI_COEF_NB;
  localparam int SUBW_NB     = AXI_COEF_NB / COEF_NB;
  localparam int BEAT_NB     = N / COEF_NB;

  // word_cnt must be able to hold WORD_NB itself (the "all words fetched" state)
  localparam int WORD_CNT_W  = cnt_w(WORD_NB + 1);
  localparam int SUBW_CNT_W  = cnt_w(SUBW_NB);
  localparam int BEAT_CNT_W  = cnt_w(BEAT_NB);
  localparam int SLOT_IDX_W  = cnt_w(AXI_COEF_NB);

  typedef struct packed {
    logic [7:0]  pid;
    logic [31:0] addr;
  } load_glwe_cmd_t;

  localparam int LOAD_GLWE_CMD_W = $bits(load_glwe_cmd_t);

  typedef enum logic [1:0] {IDLE, RUN, DONE} ldg_unpack_state_e;

endpackage

// File: rtl/pep_ldg_axi_unpack.sv
// Unpacks AXI read words (one coefficient per slot) into COEF_NB-coefficient beats.
// Optional rlast framing check enabled by defining PEP_LDG_UNPACK_RLAST_CHK_EN.
module pep_ldg_axi_unpack
  import pep_ldg_unpack_pkg::*;
(
  input  logic                       clk,
  input  logic                       s_rst_n,
  input  logic [LOAD_GLWE_CMD_W-1:0] in_cmd,
  input  logic                       in_cmd_vld,
  output logic                       in_cmd_rdy,
  input  logic [AXI_DATA_W-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready,
  output logic [COEF_NB*MOD_Q_W-1:0] out_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic                       out_last,
  output logic                       cmd_done,
  output logic                       ldg_unpack_err
`ifdef PEP_LDG_UNPACK_RLAST_CHK_EN
  ,
  output logic                       ldg_unpack_rlast_err
`endif
);

  if (COEF_NB > AXI_COEF_NB || (COEF_NB & (COEF_NB - 1)) != 0) begin : g_bad_coef_nb
    $fatal(1, "COEF_NB must be a power of 2 not above AXI_COEF_NB");
  end
  if ((AXI_COEF_NB & (AXI_COEF_NB - 1)) != 0) begin : g_bad_axi_coef_nb
    $fatal(1, "AXI_COEF_NB must be a power of 2");
  end
  if (MOD_Q_W > SLOT_W) begin : g_bad_mod_q_w
    $fatal(1, "MOD_Q_W must not exceed SLOT_W");
  end

  ldg_unpack_state_e             state;
  logic [WORD_CNT_W-1:0]         word_cnt;
  logic [SUBW_CNT_W-1:0]         subw_cnt;
  logic [BEAT_CNT_W-1:0]         beat_cnt;
  logic                          word_vld;
  logic [AXI_DATA_W-1:0]         word_q;
  logic [AXI_COEF_NB-1:0][SLOT_W-1:0] slots;
  logic                          axi_acc;
  logic                          out_acc;
  logic                          subw_last;
  logic                          beat_last;
  logic                          words_left;
  logic                          unused_ok;

  assign subw_last  = (subw_cnt == SUBW_CNT_W'(SUBW_NB - 1));
  assign beat_last  = (beat_cnt == BEAT_CNT_W'(BEAT_NB - 1));
  assign words_left = (word_cnt < WORD_CNT_W'(WORD_NB));

  assign out_vld  = word_vld;
  assign out_last = word_vld & beat_last;
  assign out_acc  = word_vld & out_rdy;

  // Refill in the same cycle the last sub-word leaves, so the stream has no bubble
  assign m_axi_rready = (state == RUN) & words_left & (!word_vld | (out_acc & subw_last));
  assign axi_acc      = m_axi_rvalid & m_axi_rready;

  assign unused_ok = ^{in_cmd, m_axi_rlast, word_q};

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state          <= IDLE;
      in_cmd_rdy     <= 1'b0;
      cmd_done       <= 1'b0;
      word_vld       <= 1'b0;
      word_cnt       <= '0;
      subw_cnt       <= '0;
      beat_cnt       <= '0;
      ldg_unpack_err <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (axi_acc) begin
        word_vld <= 1'b1;
        word_cnt <= word_cnt + 1'b1;
        if (m_axi_rresp != 2'b00) ldg_unpack_err <= 1'b1;
      end else if (out_acc && subw_last) begin
        word_vld <= 1'b0;
      end
      if (out_acc) begin
        subw_cnt <= subw_last ? '0 : subw_cnt + 1'b1;
        beat_cnt <= beat_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          in_cmd_rdy <= 1'b1;
          if (in_cmd_rdy && in_cmd_vld) begin
            state      <= RUN;
            in_cmd_rdy <= 1'b0;
            word_cnt   <= '0;
            subw_cnt   <= '0;
            beat_cnt   <= '0;
          end
        end
        RUN: begin
          if (out_acc && beat_last) begin
            state    <= DONE;
            cmd_done <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          in_cmd_rdy <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (axi_acc) word_q <= m_axi_rdata;
  end

  // Slot select: sub-word index picks a COEF_NB-wide window, high slot bits dropped
  assign slots = word_q;
  always_comb begin
    out_data = '0;
    for (int i = 0; i < COEF_NB; i++) begin
      out_data[i*MOD_Q_W +: MOD_Q_W] =
        slots[SLOT_IDX_W'(int'(subw_cnt) * COEF_NB + i)][MOD_Q_W-1:0];
    end
  end

`ifdef PEP_LDG_UNPACK_RLAST_CHK_EN
  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ldg_unpack_rlast_err <= 1'b0;
    end else if (axi_acc && (m_axi_rlast != (word_cnt == WORD_CNT_W'(WORD_NB - 1)))) begin
      ldg_unpack_rlast_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pep_ldg_axi_unpack.sv
// Scoreboard bench for pep_ldg_axi_unpack: directed load commands, back-pressure,
// rresp error, mid-command reset.
module tb_pep_ldg_axi_unpack;
  import pep_ldg_unpack_pkg::*;

  localparam int OUT_W = COEF_NB * MOD_Q_W;

  logic                       clk = 1'b0;
  logic                       s_rst_n;
  logic [LOAD_GLWE_CMD_W-1:0] in_cmd;
  logic                       in_cmd_vld;
  logic                       in_cmd_rdy;
  logic [AXI_DATA_W-1:0]      m_axi_rdata;
  logic [1:0]                 m_axi_rresp;
  logic                       m_axi_rlast;
  logic                       m_axi_rvalid;
  logic                       m_axi_rready;
  logic [OUT_W-1:0]           out_data;
  logic                       out_vld;
  logic                       out_rdy;
  logic                       out_last;
  logic                       cmd_done;
  logic                       ldg_unpack_err;

  always #5 clk = ~clk;

  pep_ldg_axi_unpack dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .in_cmd(in_cmd), .in_cmd_vld(in_cmd_vld), .in_cmd_rdy(in_cmd_rdy),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .cmd_done(cmd_done), .ldg_unpack_err(ldg_unpack_err)
  );

  typedef logic [OUT_W:0] exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_total = 0;
  int done_cnt = 0;
  bit bp = 0;
  bit abort = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [OUT_W:0] act, input logic [OUT_W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // mode 0: slot k of every word = k; mode 1: all ones; mode 2: {1, base + global coef index}
  function automatic logic [SLOT_W-1:0] slot_val(input int mode, input int base, input int w, input int k);
    if (mode == 0) return SLOT_W'(k);
    if (mode == 1) return 32'hFFFF_FFFF;
    return {1'b1, 31'(base + w * AXI_COEF_NB + k)};
  endfunction

  function automatic logic [MOD_Q_W-1:0] coef_exp(input int mode, input int base, input int c);
    if (mode == 0) return MOD_Q_W'(c % AXI_COEF_NB);
    if (mode == 1) return 31'h7FFF_FFFF;
    return 31'(base + c);
  endfunction

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  logic [OUT_W-1:0] stall_data;
  bit stall_prev = 0;
  bit last_hs_prev = 0;

  always @(negedge clk) begin
    if (!s_rst_n) begin
      stall_prev   = 0;
      last_hs_prev = 0;
    end else begin
      if (stall_prev) check("stall_hold", {out_vld, out_data}, {1'b1, stall_data});
      if (cmd_done || last_hs_prev) check("cmd_done_timing", cmd_done, last_hs_prev);
      if (cmd_done) done_cnt++;
      stall_prev   = 0;
      last_hs_prev = 0;
      if (out_vld && out_rdy) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {out_last, out_data}, '1);
        end else begin
          check("beat", {out_last, out_data}, exp_q.pop_front());
        end
        last_hs_prev = out_last;
      end else if (out_vld) begin
        stall_prev = 1;
        stall_data = out_data;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic run_cmd(input int mode, input int base, input int err_word, input bit chk_lat);
    load_glwe_cmd_t cmd;
    logic [OUT_W-1:0] d;
    int c0;
    int t;
    bit ok;
    bit hs;
    for (int b = 0; b < BEAT_NB; b++) begin
      for (int i = 0; i < COEF_NB; i++) d[i*MOD_Q_W +: MOD_Q_W] = coef_exp(mode, base, b * COEF_NB + i);
      exp_q.push_back({(b == BEAT_NB - 1), d});
    end
    cmd.pid  = 8'(base);
    cmd.addr = 32'h0000_1000;
    in_cmd = cmd;
    in_cmd_vld = 1'b1;
    ok = 0; t = 0;
    while (!ok && !abort && t < 100) begin
      #7 hs = in_cmd_rdy;
      @(posedge clk); #1;
      ok = hs; t++;
    end
    in_cmd_vld = 1'b0;
    if (!ok && !abort) check("cmd_accept_timeout", 0, 1);
    c0 = cyc;
    for (int w = 0; w < WORD_NB && !abort; w++) begin
      for (int k = 0; k < AXI_COEF_NB; k++) m_axi_rdata[k*SLOT_W +: SLOT_W] = slot_val(mode, base, w, k);
      m_axi_rresp  = (w == err_word) ? 2'b10 : 2'b00;
      m_axi_rlast  = (w == WORD_NB - 1);
      m_axi_rvalid = 1'b1;
      ok = 0; t = 0;
      while (!ok && !abort && t < 200) begin
        #7 hs = m_axi_rready;
        @(posedge clk); #1;
        ok = hs; t++;
      end
      if (!ok && !abort) check("axi_word_timeout", 0, 1);
    end
    m_axi_rvalid = 1'b0;
    ok = 0; t = 0;
    while (!ok && !abort && t < 300) begin
      @(negedge clk);
      ok = cmd_done; t++;
    end
    if (!ok && !abort) check("cmd_done_timeout", 0, 1);
    if (ok && chk_lat) check("cmd_latency", cyc - c0, BEAT_NB + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int t;
    s_rst_n = 1'b0;
    in_cmd = '0; in_cmd_vld = 1'b0;
    m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_cmd_rdy", in_cmd_rdy, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_err", ldg_unpack_err, 0);
    s_rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_cmd_rdy", in_cmd_rdy, 1);

    // AXI data offered before any command must be held off
    m_axi_rvalid = 1'b1;
    m_axi_rdata = {AXI_DATA_W{1'b1}};
    repeat (3) begin
      #3 check("rready_before_cmd", m_axi_rready, 0);
      @(posedge clk); #1;
    end
    m_axi_rvalid = 1'b0;

    run_cmd(0, 0, -1, 1);
    check("done_cnt_1", done_cnt, 1);

    bp = 1;
    run_cmd(2, 'h100, -1, 0);
    bp = 0;

    run_cmd(2, 'h200, -1, 0);
    run_cmd(2, 'h300, -1, 0);
    check("done_cnt_4", done_cnt, 4);

    run_cmd(1, 0, -1, 0);
    check("err_clear_before", ldg_unpack_err, 0);

    run_cmd(2, 'h400, 3, 0);
    check("err_set", ldg_unpack_err, 1);
    run_cmd(2, 'h500, -1, 0);
    check("err_sticky", ldg_unpack_err, 1);
    check("queue_empty_mid", exp_q.size(), 0);
    check("done_cnt_7", done_cnt, 7);

    fork
      run_cmd(2, 'h600, -1, 0);
      begin
        start = hs_total;
        t = 0;
        while (hs_total - start < 10 && t < 200) begin
          @(negedge clk);
          t++;
        end
        if (hs_total - start < 10) check("reset_point_timeout", 0, 1);
        #1;
        s_rst_n = 1'b0;
        abort = 1;
        exp_q.delete();
        #1;
        check("midrst_out_vld", out_vld, 0);
        check("midrst_out_last", out_last, 0);
        check("midrst_rready", m_axi_rready, 0);
        check("midrst_in_cmd_rdy", in_cmd_rdy, 0);
        check("midrst_cmd_done", cmd_done, 0);
        check("midrst_err", ldg_unpack_err, 0);
      end
    join
    abort = 0;
    @(posedge clk); #1;
    s_rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_cmd_rdy", in_cmd_rdy, 1);
    run_cmd(2, 'h700, -1, 1);
    check("done_cnt_final", done_cnt, 8);
    check("queue_empty_end", exp_q.size(), 0);
    check("err_after_reset", ldg_unpack_err, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
